// File: rtl/ripple_count_sampler_if.sv
// Output handshake bundle of ripple_count_sampler: accepted count plus its wrap qualifier.
// The master drives the value and the slave returns out_ready.
interface ripple_count_sampler_if #(
    parameter int WIDTH = 4
);
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_wrap;

    modport master (
        output out_valid,
        output out_data,
        output out_wrap,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_wrap,
        output out_ready
    );
endinterface

// File: rtl/ripple_count_sampler.sv
// Brings an asynchronous ripple-counter value into the clk domain. A value is accepted only
// after STABLE equal synchronized samples, then offered on a valid/ready slot.
module ripple_count_sampler #(
    parameter int               WIDTH    = 4,
    parameter int               STABLE   = 2,
    parameter logic [WIDTH-1:0] TERMINAL = {WIDTH{1'b1}}
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [WIDTH-1:0]        cnt_in,
    input  logic                    clear_overrun,
    output logic                    tc_hit,
    output logic                    overrun,
    ripple_count_sampler_if.master  out_if
);

    typedef enum logic {
        ST_LOCKED = 1'b0,
        ST_SETTLE = 1'b1
    } state_t;

    localparam logic [3:0] RUN_LAST = 4'(STABLE - 1);

    logic [WIDTH-1:0] s_sync;

    // Bits are synchronized independently; coherence comes from the stability filter.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_sync
            logic meta_q;
            logic samp_q;
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    meta_q <= 1'b0;
                    samp_q <= 1'b0;
                end else begin
                    meta_q <= cnt_in[gi];
                    samp_q <= meta_q;
                end
            end
            assign s_sync[gi] = samp_q;
        end
    endgenerate

    state_t           state_q, state_d;
    logic [WIDTH-1:0] cand_q, cand_d;
    logic [3:0]       run_q, run_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             wrap_q, wrap_d;
    logic             overrun_q, overrun_d;
    logic             tc_q;
    logic             accept;
    logic             slot_free;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_LOCKED;
            cand_q    <= '0;
            run_q     <= '0;
            acc_q     <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            wrap_q    <= 1'b0;
            overrun_q <= 1'b0;
            tc_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cand_q    <= cand_d;
            run_q     <= run_d;
            acc_q     <= acc_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            wrap_q    <= wrap_d;
            overrun_q <= overrun_d;
            tc_q      <= (acc_q == TERMINAL);
        end
    end

    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        run_d   = run_q;
        accept  = 1'b0;

        case (state_q)
            ST_LOCKED: begin
                if (s_sync != cand_q) begin
                    cand_d  = s_sync;
                    run_d   = '0;
                    state_d = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (s_sync != cand_q) begin
                    cand_d = s_sync;
                    run_d  = '0;
                end else if (run_q == RUN_LAST) begin
                    state_d = ST_LOCKED;
                    // Settling back onto the already accepted value is not news.
                    accept  = (cand_q != acc_q);
                end else begin
                    run_d = run_q + 4'd1;
                end
            end
            default: state_d = ST_LOCKED;
        endcase
    end

    assign slot_free = !valid_q || out_if.out_ready;

    always_comb begin
        acc_d     = acc_q;
        data_d    = data_q;
        valid_d   = valid_q;
        wrap_d    = wrap_q;
        overrun_d = overrun_q;

        if (accept) begin
            acc_d = cand_q;
            if (slot_free) begin
                data_d  = cand_q;
                wrap_d  = (cand_q < acc_q);
                valid_d = 1'b1;
            end
        end else if (valid_q && out_if.out_ready) begin
            valid_d = 1'b0;
        end

        // A drop on the same edge as a clear keeps the flag set.
        if (accept && !slot_free) begin
            overrun_d = 1'b1;
        end else if (clear_overrun) begin
            overrun_d = 1'b0;
        end
    end

    assign out_if.out_valid = valid_q;
    assign out_if.out_data  = data_q;
    assign out_if.out_wrap  = wrap_q;
    assign tc_hit           = tc_q;
    assign overrun          = overrun_q;

endmodule

// File: tb/tb_ripple_count_sampler.sv
// Directed bench for ripple_count_sampler (WIDTH=4, STABLE=2, TERMINAL=15).
module tb_ripple_count_sampler;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:0] cnt_in;
    logic       clear_overrun;
    logic       tc_hit;
    logic       overrun;

    int errors = 0;
    int checks = 0;

    ripple_count_sampler_if #(.WIDTH(4)) bus ();

    ripple_count_sampler #(
        .WIDTH(4),
        .STABLE(2),
        .TERMINAL(4'd15)
    ) dut (
        .clk          (clk),
        .reset        (reset_n),
        .cnt_in       (cnt_in),
        .clear_overrun(clear_overrun),
        .tc_hit       (tc_hit),
        .overrun      (overrun),
        .out_if       (bus.master)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (reset_n && bus.out_valid && bus.out_ready)
            $display("xfer data=%0d wrap=%0d t=%0t", bus.out_data, bus.out_wrap, $time);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; cnt_in = 4'd9; bus.out_ready = 1'b1; clear_overrun = 1'b0;
        repeat (4) step();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0d exp=0", bus.out_valid); end
        checks++; if (bus.out_data !== 4'd0) begin errors++; $display("FAIL reset_data got=%0d exp=0", bus.out_data); end
        checks++; if (bus.out_wrap !== 1'b0) begin errors++; $display("FAIL reset_wrap got=%0d exp=0", bus.out_wrap); end
        checks++; if (tc_hit !== 1'b0) begin errors++; $display("FAIL reset_tc got=%0d exp=0", tc_hit); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got=%0d exp=0", overrun); end
        cnt_in = 4'd0;
        reset_n = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            step();
            checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_idle_valid edge=%0d got=%0d exp=0", k, bus.out_valid); end
        end
    endtask

    task automatic test_clean_step();
        cnt_in = 4'd5;
        for (int k = 1; k <= 8; k++) begin
            step();
            checks++;
            if (bus.out_valid !== (k == 5)) begin
                errors++; $display("FAIL clean_valid edge=%0d got=%0d exp=%0d", k, bus.out_valid, (k == 5));
            end
            if (k == 5) begin
                checks++; if (bus.out_data !== 4'd5) begin errors++; $display("FAIL clean_data got=%0d exp=5", bus.out_data); end
                checks++; if (bus.out_wrap !== 1'b0) begin errors++; $display("FAIL clean_wrap got=%0d exp=0", bus.out_wrap); end
            end
        end
    endtask

    task automatic test_transient();
        int pulses;
        int seen7;
        logic [3:0] last;
        logic       last_wrap;
        cnt_in = 4'd3;
        pulses = 0; last = 4'hx; last_wrap = 1'bx;
        for (int k = 1; k <= 8; k++) begin
            step();
            if (bus.out_valid) begin pulses++; last = bus.out_data; last_wrap = bus.out_wrap; end
        end
        checks++; if (pulses !== 1) begin errors++; $display("FAIL settle3_count got=%0d exp=1", pulses); end
        checks++; if (last !== 4'd3) begin errors++; $display("FAIL settle3_data got=%0d exp=3", last); end
        checks++; if (last_wrap !== 1'b1) begin errors++; $display("FAIL settle3_wrap got=%0d exp=1", last_wrap); end
        cnt_in = 4'd7;
        step();
        cnt_in = 4'd4;
        pulses = 0; seen7 = 0; last = 4'hx;
        for (int k = 1; k <= 10; k++) begin
            step();
            if (bus.out_valid) begin
                pulses++; last = bus.out_data;
                if (bus.out_data == 4'd7) seen7++;
            end
        end
        checks++; if (pulses !== 1) begin errors++; $display("FAIL glitch_count got=%0d exp=1", pulses); end
        checks++; if (last !== 4'd4) begin errors++; $display("FAIL glitch_data got=%0d exp=4", last); end
        checks++; if (seen7 !== 0) begin errors++; $display("FAIL glitch_seen7 got=%0d exp=0", seen7); end
    endtask

    task automatic test_wrap_tc();
        cnt_in = 4'd15;
        repeat (5) step();
        checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 4'd15) begin errors++; $display("FAIL tc_accept got=%0d/%0d exp=1/15", bus.out_valid, bus.out_data); end
        checks++; if (tc_hit !== 1'b0) begin errors++; $display("FAIL tc_early got=%0d exp=0", tc_hit); end
        step();
        checks++; if (tc_hit !== 1'b1) begin errors++; $display("FAIL tc_set got=%0d exp=1", tc_hit); end
        repeat (3) step();
        cnt_in = 4'd0;
        repeat (5) step();
        checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 4'd0) begin errors++; $display("FAIL wrap_accept got=%0d/%0d exp=1/0", bus.out_valid, bus.out_data); end
        checks++; if (bus.out_wrap !== 1'b1) begin errors++; $display("FAIL wrap_flag got=%0d exp=1", bus.out_wrap); end
        checks++; if (tc_hit !== 1'b1) begin errors++; $display("FAIL tc_hold got=%0d exp=1", tc_hit); end
        step();
        checks++; if (tc_hit !== 1'b0) begin errors++; $display("FAIL tc_clear got=%0d exp=0", tc_hit); end
        repeat (3) step();
    endtask

    task automatic test_backpressure();
        bus.out_ready = 1'b0;
        cnt_in = 4'd1;
        repeat (5) step();
        checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 4'd1) begin errors++; $display("FAIL bp_first got=%0d/%0d exp=1/1", bus.out_valid, bus.out_data); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL bp_no_overrun got=%0d exp=0", overrun); end
        cnt_in = 4'd2;
        repeat (5) step();
        checks++; if (bus.out_data !== 4'd1 || bus.out_wrap !== 1'b0) begin errors++; $display("FAIL bp_hold got=%0d/%0d exp=1/0", bus.out_data, bus.out_wrap); end
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL bp_overrun got=%0d exp=1", overrun); end
        cnt_in = 4'd3;
        repeat (4) step();
        clear_overrun = 1'b1;
        step();
        clear_overrun = 1'b0;
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL bp_set_beats_clear got=%0d exp=1", overrun); end
        step();
        clear_overrun = 1'b1;
        step();
        clear_overrun = 1'b0;
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL bp_clear got=%0d exp=0", overrun); end
        checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 4'd1) begin errors++; $display("FAIL bp_pending got=%0d/%0d exp=1/1", bus.out_valid, bus.out_data); end
        bus.out_ready = 1'b1;
        step();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL bp_transfer got=%0d exp=0", bus.out_valid); end
    endtask

    task automatic test_back_to_back();
        bus.out_ready = 1'b0;
        cnt_in = 4'd8;
        repeat (5) step();
        checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 4'd8) begin errors++; $display("FAIL b2b_first got=%0d/%0d exp=1/8", bus.out_valid, bus.out_data); end
        cnt_in = 4'd9;
        repeat (4) step();
        bus.out_ready = 1'b1;
        step();
        checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 4'd9) begin errors++; $display("FAIL b2b_reload got=%0d/%0d exp=1/9", bus.out_valid, bus.out_data); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL b2b_overrun got=%0d exp=0", overrun); end
        step();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain got=%0d exp=0", bus.out_valid); end
    endtask

    task automatic test_reset_mid();
        bus.out_ready = 1'b0;
        cnt_in = 4'd12;
        repeat (5) step();
        checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 4'd12) begin errors++; $display("FAIL mid_pending got=%0d/%0d exp=1/12", bus.out_valid, bus.out_data); end
        cnt_in = 4'd13;
        repeat (3) step();
        #2 reset_n = 1'b0;
        #1;
        checks++; if (bus.out_valid !== 1'b0 || bus.out_data !== 4'd0) begin errors++; $display("FAIL mid_async got=%0d/%0d exp=0/0", bus.out_valid, bus.out_data); end
        checks++; if (tc_hit !== 1'b0 || overrun !== 1'b0 || bus.out_wrap !== 1'b0) begin errors++; $display("FAIL mid_flags got=%0d/%0d/%0d exp=0/0/0", tc_hit, overrun, bus.out_wrap); end
        bus.out_ready = 1'b1;
        cnt_in = 4'd6;
        step();
        step();
        reset_n = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            step();
            checks++;
            if (bus.out_valid !== (k == 5)) begin
                errors++; $display("FAIL mid_valid edge=%0d got=%0d exp=%0d", k, bus.out_valid, (k == 5));
            end
            if (k == 5) begin
                checks++; if (bus.out_data !== 4'd6 || bus.out_wrap !== 1'b0) begin errors++; $display("FAIL mid_data got=%0d/%0d exp=6/0", bus.out_data, bus.out_wrap); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_clean_step();
        test_transient();
        test_wrap_tc();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
